// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - vector instruction and hazard operand counts shared by the vector unit
package ara_pkg;
    localparam int unsigned NrVInsn          = 8;
    localparam int unsigned NrHazardOperands = 3;
endpackage

// File: rtl/insn_progress_tracker.sv
// rtl/insn_progress_tracker.sv - per-slot VRF read/write progress counters for in-flight vector instructions
// Optional macro PROGRESS_ERR_FLAG_EN enables the sticky protocol error flag.
module insn_progress_tracker
    import ara_pkg::*;
#(
    parameter type vaddr_t = logic,
    localparam int unsigned W   = $bits(vaddr_t),
    localparam int unsigned IdW = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             issue_valid_i,
    input  logic [IdW-1:0]                                   issue_id_i,
    input  logic [NrHazardOperands-1:0][W-1:0]               issue_raddr_i,
    input  logic [NrHazardOperands-1:0]                      issue_rmask_i,
    input  logic [W-1:0]                                     issue_waddr_i,
    input  logic [NrVInsn-1:0][NrHazardOperands-1:0]         read_grant_i,
    input  logic [NrVInsn-1:0]                               write_grant_i,
    input  logic [NrVInsn-1:0][NrHazardOperands-1:0]         read_done_i,
    input  logic [NrVInsn-1:0]                               write_done_i,
    output logic [NrVInsn-1:0][NrHazardOperands-1:0][W-1:0]  insn_read_proceed_o,
    output logic [NrVInsn-1:0][W-1:0]                        insn_write_proceed_o,
    output logic [NrVInsn-1:0]                               slot_busy_o,
    output logic                                             error_o
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] SAT = MAX - W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WDRAIN = 2'd2
    } slot_state_e;

`ifdef PROGRESS_ERR_FLAG_EN
    logic [NrVInsn-1:0] slot_err;
`endif

    for (genvar i = 0; i < NrVInsn; i++) begin : g_slot
        slot_state_e                        state_q, state_d;
        logic [NrHazardOperands-1:0][W-1:0] rd_q, rd_d;
        logic [W-1:0]                       wr_q, wr_d;
        logic                               issue_hit;

        assign issue_hit = issue_valid_i && (issue_id_i == IdW'(i));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                rd_q    <= '1;
                wr_q    <= MAX;
            end else begin
                state_q <= state_d;
                rd_q    <= rd_d;
                wr_q    <= wr_d;
            end
        end

        always_comb begin
            state_d = state_q;
            rd_d    = rd_q;
            wr_d    = wr_q;
            case (state_q)
                IDLE: begin
                    if (issue_hit) begin
                        state_d = ACTIVE;
                        for (int k = 0; k < NrHazardOperands; k++) begin
                            rd_d[k] = issue_rmask_i[k] ? issue_raddr_i[k] : MAX;
                        end
                        wr_d = issue_waddr_i;
                    end
                end
                default: begin
                    if (write_grant_i[i]) begin
                        wr_d = (wr_q >= SAT) ? SAT : wr_q + W'(1);
                    end
                    for (int k = 0; k < NrHazardOperands; k++) begin
                        if (read_done_i[i][k]) begin
                            rd_d[k] = MAX;
                        end else if (read_grant_i[i][k] && state_q == ACTIVE && rd_q[k] < SAT) begin
                            rd_d[k] = rd_q[k] + W'(1);
                        end
                    end
                    // Drain decision looks at the registered counters, so it lags the last read by a cycle.
                    if (state_q == ACTIVE && (&rd_q)) begin
                        state_d = WDRAIN;
                    end
                    if (write_done_i[i]) begin
                        state_d = IDLE;
                        rd_d    = '1;
                        wr_d    = MAX;
                    end
                end
            endcase
        end

`ifdef PROGRESS_ERR_FLAG_EN
        // Any counter at SAT or MAX can no longer advance, so a grant to it is a protocol error.
        always_comb begin
            slot_err[i] = 1'b0;
            if (state_q == IDLE) begin
                slot_err[i] = (|read_grant_i[i]) || write_grant_i[i];
            end else begin
                if (issue_hit || (write_grant_i[i] && wr_q >= SAT)) begin
                    slot_err[i] = 1'b1;
                end
                for (int k = 0; k < NrHazardOperands; k++) begin
                    if (read_grant_i[i][k] && rd_q[k] >= SAT) begin
                        slot_err[i] = 1'b1;
                    end
                end
            end
        end
`endif

        assign insn_read_proceed_o[i]  = rd_q;
        assign insn_write_proceed_o[i] = wr_q;
        assign slot_busy_o[i]          = (state_q != IDLE);
    end

`ifdef PROGRESS_ERR_FLAG_EN
    logic error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else if (|slot_err) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
